// File: rtl/ethernet_header_pkg.sv
// ethernet_header_pkg: shared constants and FSM state type for the Ethernet header streamer.
// Optional feature macro: ETH_HDR_VLAN_EN (adds a 4-byte 802.1Q tag to the header).
package ethernet_header_pkg;
    localparam int          ETH_MAC_BYTES  = 6;
    localparam int          ETH_HDR_BYTES  = 14;
    localparam logic [15:0] ETH_VLAN_TPID  = 16'h8100;
    localparam int          ETH_VLAN_BYTES = 4;
`ifdef ETH_HDR_VLAN_EN
    localparam int          HDR_TOTAL      = ETH_HDR_BYTES + ETH_VLAN_BYTES;
`else
    localparam int          HDR_TOTAL      = ETH_HDR_BYTES;
`endif
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} eth_state_t;
endpackage

// File: rtl/eth_hdr_byte_mux.sv
// eth_hdr_byte_mux: combinational selection of one header byte (network order) by index.
// Ports: dest_mac/src_mac/len (and vlan_tci with ETH_HDR_VLAN_EN) latched fields in,
//        idx byte index in, data selected header byte out.
module eth_hdr_byte_mux
    import ethernet_header_pkg::*;
(
    input  logic [8*ETH_MAC_BYTES-1:0] dest_mac,
    input  logic [8*ETH_MAC_BYTES-1:0] src_mac,
`ifdef ETH_HDR_VLAN_EN
    input  logic [15:0]                vlan_tci,
`endif
    input  logic [15:0]                len,
    input  logic [4:0]                 idx,
    output logic [7:0]                 data
);
    localparam int W = 8 * HDR_TOTAL;
    logic [W-1:0] hdr;
    logic [W-1:0] shifted;
`ifdef ETH_HDR_VLAN_EN
    assign hdr = {dest_mac, src_mac, ETH_VLAN_TPID, vlan_tci, len};
`else
    assign hdr = {dest_mac, src_mac, len};
`endif
    // Shifting left keeps the selected byte at the top, so no out-of-range part-select exists.
    assign shifted = hdr << {idx, 3'b000};
    assign data    = shifted[W-1 -: 8];
endmodule

// File: rtl/eth_header_streamer.sv
// eth_header_streamer: emits an Ethernet header, streams the payload through, then zero-pads
// short frames up to MIN_PAYLOAD_BYTES.
// Ports: clk, rst_n (async active-low); start/cfg_len/cfg_dest_mac/cfg_src_mac frame request;
//        s_data/s_valid/s_ready payload in; m_data/m_valid/m_ready/m_last frame out;
//        busy frame in progress; err_len one-cycle pulse on an oversize request.
// Optional macro ETH_HDR_VLAN_EN adds port vlan_tci and an 802.1Q tag in the header.
module eth_header_streamer
    import ethernet_header_pkg::*;
#(
    parameter logic [47:0] SOURCE_MAC        = 48'he86a64e7e830,
    parameter logic [47:0] DEST_MAC          = 48'he86a64e7e829,
    parameter int          MAX_PAYLOAD_BYTES = 1500,
    parameter int          MIN_PAYLOAD_BYTES = 46
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cfg_len,
`ifdef ETH_HDR_VLAN_EN
    input  logic [15:0] vlan_tci,
`endif
    input  logic [47:0] cfg_dest_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        err_len
);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD_BYTES);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD_BYTES);
    localparam logic [15:0] HDR_LAST = 16'(HDR_TOTAL - 1);

    eth_state_t  state, state_nx;
    logic [15:0] cnt, cnt_nx, len_q;
    logic [47:0] dst_q, src_q;
    logic [7:0]  hdr_byte;
    logic        accept;
`ifdef ETH_HDR_VLAN_EN
    logic [15:0] vlan_q;
`endif

    eth_hdr_byte_mux u_mux (
        .dest_mac (dst_q),
        .src_mac  (src_q),
`ifdef ETH_HDR_VLAN_EN
        .vlan_tci (vlan_q),
`endif
        .len      (len_q),
        .idx      (cnt[4:0]),
        .data     (hdr_byte)
    );

    assign busy = state != IDLE;

    // cnt indexes header bytes in HEADER, then counts payload+pad bytes from zero.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_last   = 1'b0;
        case (state)
            IDLE: begin
                if (start && cfg_len <= MAX_LEN) begin
                    accept   = 1'b1;
                    cnt_nx   = 16'd0;
                    state_nx = HEADER;
                end
            end
            HEADER: begin
                m_valid = 1'b1;
                m_data  = hdr_byte;
                if (m_ready) begin
                    cnt_nx = cnt + 16'd1;
                    if (cnt == HDR_LAST) begin
                        cnt_nx   = 16'd0;
                        state_nx = len_q != 16'd0 ? PAYLOAD : PAD;
                    end
                end
            end
            PAYLOAD: begin
                s_ready = m_ready;
                m_valid = s_valid;
                m_data  = s_data;
                m_last  = cnt == len_q - 16'd1 && len_q >= MIN_LEN;
                if (s_valid && m_ready) begin
                    cnt_nx = cnt + 16'd1;
                    if (cnt == len_q - 16'd1) state_nx = len_q < MIN_LEN ? PAD : IDLE;
                end
            end
            PAD: begin
                m_valid = 1'b1;
                m_last  = cnt == MIN_LEN - 16'd1;
                if (m_ready) begin
                    cnt_nx = cnt + 16'd1;
                    if (cnt == MIN_LEN - 16'd1) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            len_q   <= 16'd0;
            dst_q   <= DEST_MAC;
            src_q   <= SOURCE_MAC;
            err_len <= 1'b0;
`ifdef ETH_HDR_VLAN_EN
            vlan_q  <= 16'd0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            err_len <= state == IDLE && start && cfg_len > MAX_LEN;
            if (accept) begin
                len_q <= cfg_len;
                dst_q <= cfg_dest_mac;
                src_q <= cfg_src_mac;
`ifdef ETH_HDR_VLAN_EN
                vlan_q <= vlan_tci;
`endif
            end
        end
    end
endmodule

// File: tb/tb_eth_header_streamer.sv
// tb_eth_header_streamer: table-driven and randomized checks of eth_header_streamer against
// a byte-queue reference frame built from the header/payload/pad rules.
module tb_eth_header_streamer;
`ifdef ETH_HDR_VLAN_EN
    localparam int HDR_N = 18;
`else
    localparam int HDR_N = 14;
`endif
    localparam logic [47:0] DST = 48'he86a64e7e829;
    localparam logic [47:0] SRC = 48'he86a64e7e830;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
    logic        s_ready, m_valid, m_last, busy, err_len;
    logic [15:0] cfg_len = 16'd0, vlan_tci = 16'd0;
    logic [47:0] cfg_dest_mac = 48'd0, cfg_src_mac = 48'd0;
    logic [7:0]  s_data = 8'd0, m_data;

    int checks = 0, errors = 0;
    logic [7:0] exp_q[$], pay[$], got[$];

    typedef struct {
        logic [15:0] len;
        bit          rnd;
        bit          extra;
        int          pl;
        bit          err;
    } vec_t;
    vec_t tbl[9];

    eth_header_streamer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_len      (cfg_len),
`ifdef ETH_HDR_VLAN_EN
        .vlan_tci     (vlan_tci),
`endif
        .cfg_dest_mac (cfg_dest_mac),
        .cfg_src_mac  (cfg_src_mac),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy),
        .err_len      (err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic build_exp(input logic [15:0] len, input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] tci);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(s[47-8*i -: 8]);
`ifdef ETH_HDR_VLAN_EN
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h00);
        exp_q.push_back(tci[15:8]);
        exp_q.push_back(tci[7:0]);
`endif
        exp_q.push_back(len[15:8]);
        exp_q.push_back(len[7:0]);
        for (int i = 0; i < int'(len); i++) exp_q.push_back(pay[i]);
        while (exp_q.size() < HDR_N + 46) exp_q.push_back(8'h00);
    endtask

    task automatic run_frame(input logic [15:0] len, input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] tci, input bit rnd, input bit extra,
                             input int abort_at, output int nbytes);
        int n = 0, pi = 0;
        bit stall = 0, done = 0, aborted = 0, taken = 0, saw = 0;
        logic [9:0] prev = '0;
        pay.delete();
        got.delete();
        for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
        build_exp(len, d, s, tci);
        @(negedge clk);
        start = 1'b1; cfg_len = len; cfg_dest_mac = d; cfg_src_mac = s; vlan_tci = tci;
        s_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            start = extra && cyc == 3;
            if (start) begin
                cfg_len = 16'd2000; cfg_dest_mac = '1; cfg_src_mac = '0; vlan_tci = 16'hffff;
            end
            if (taken) begin s_valid = 1'b0; pi++; taken = 0; end
            if (!s_valid && pi < int'(len)) begin
                s_valid = rnd ? 1'($urandom) : 1'b1;
                s_data  = pay[pi];
            end
            m_ready = rnd ? 1'($urandom) : 1'b1;
            #1;
            if (cyc == 0) begin
                chk("busy_after_start", busy, 1);
                chk("first_header_valid", m_valid, 1);
            end
            if (stall) chk("stable_when_stalled", {m_valid, m_last, m_data}, prev);
            if (err_len) chk("err_len_in_frame", err_len, 0);
            if (s_ready) begin
                saw = 1;
                chk("s_ready_in_payload_only", n >= HDR_N && n < HDR_N + int'(len), 1);
            end
            stall = m_valid && !m_ready;
            prev  = {m_valid, m_last, m_data};
            taken = s_valid && s_ready;
            if (m_valid && m_ready) begin
                if (n >= exp_q.size()) chk("frame_overrun", n, exp_q.size() - 1);
                else chk("byte", m_data, exp_q[n]);
                chk("m_last_position", m_last, n == exp_q.size() - 1);
                got.push_back(m_data);
                n++;
                if (m_last) done = 1;
                if (n == abort_at) begin done = 1; aborted = 1; end
            end
        end
        nbytes = n;
        start = 1'b0;
        chk("frame_completed", done, 1);
        if (aborted) return;
        if (taken) pi++;
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("busy_clear_after_last", busy, 0);
        chk("idle_no_valid", m_valid, 0);
        chk("payload_consumed", pi, len);
        if (len == 16'd0) chk("no_s_ready_zero_len", saw, 0);
    endtask

    initial begin
        int nb;
        tbl[0] = '{16'd64,   0, 0, 64,   0};
        tbl[1] = '{16'd10,   0, 0, 46,   0};
        tbl[2] = '{16'd0,    0, 0, 46,   0};
        tbl[3] = '{16'd46,   0, 0, 46,   0};
        tbl[4] = '{16'd47,   0, 0, 47,   0};
        tbl[5] = '{16'd1501, 0, 0, 0,    1};
        tbl[6] = '{16'd45,   1, 0, 46,   0};
        tbl[7] = '{16'd1500, 0, 0, 1500, 0};
        tbl[8] = '{16'd64,   1, 1, 64,   0};

        repeat (3) @(negedge clk);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_err_len", err_len, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_last", m_last, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].err) begin
                @(negedge clk);
                start = 1'b1; cfg_len = tbl[i].len;
                @(negedge clk);
                start = 1'b0;
                #1;
                chk("err_len_pulse", err_len, 1);
                chk("err_busy", busy, 0);
                chk("err_no_valid", m_valid, 0);
                @(negedge clk);
                #1;
                chk("err_len_one_cycle", err_len, 0);
                chk("err_still_idle", {busy, m_valid}, 0);
            end else begin
                run_frame(tbl[i].len, DST, SRC, 16'h0005, tbl[i].rnd, tbl[i].extra, -1, nb);
                chk("total_bytes", nb, HDR_N + tbl[i].pl);
                if (i == 0) begin
                    chk("hdr_byte0", got[0], 8'he8);
                    chk("hdr_byte5", got[5], 8'h29);
                    chk("len_hi", got[HDR_N-2], 8'h00);
                    chk("len_lo", got[HDR_N-1], 8'h40);
                end
            end
        end

        for (int k = 0; k < 8; k++) begin
            logic [15:0] len;
            len = 16'($urandom_range(0, 100));
            run_frame(len, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 1,
                      1'($urandom), -1, nb);
            chk("rand_total_bytes", nb, HDR_N + (len < 16'd46 ? 46 : int'(len)));
        end

        run_frame(16'd46, DST, SRC, 16'h0005, 0, 0, 5, nb);
        rst_n = 1'b0;
        #1;
        chk("abort_m_valid", m_valid, 0);
        chk("abort_m_last", m_last, 0);
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_m_data", m_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(16'd46, DST, SRC, 16'h0005, 0, 0, -1, nb);
        chk("after_reset_total", nb, HDR_N + 46);
`ifdef ETH_HDR_VLAN_EN
        chk("vlan_tpid_hi", got[12], 8'h81);
        chk("vlan_tpid_lo", got[13], 8'h00);
        chk("vlan_tci_hi", got[14], 8'h00);
        chk("vlan_tci_lo", got[15], 8'h05);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_header_streamer.md
ETH_HEADER_STREAMER -- requirements
Module: eth_header_streamer

Interface
REQ-001 The block SHALL have parameter SOURCE_MAC, default 48'he86a64e7e830, power-up source MAC.
REQ-002 The block SHALL have parameter DEST_MAC, default 48'he86a64e7e829, power-up destination MAC.
REQ-003 The block SHALL have parameter MAX_PAYLOAD_BYTES, default 1500, largest accepted length.
REQ-004 The block SHALL have parameter MIN_PAYLOAD_BYTES, default 46, zero-pad target.
REQ-005 The block SHALL have the following ports: clk  in  1  single clock, all logic on rising edge.
REQ-006 The block SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have ports start  in  1  frame request; cfg_len  in  16  payload bytes.
REQ-008 The block SHALL have ports cfg_dest_mac  in  48  and cfg_src_mac  in  48, sampled with start.
REQ-009 The block SHALL have ports s_data  in  8, s_valid  in  1, s_ready  out  1 (payload input).
REQ-010 The block SHALL have ports m_data  out  8, m_valid  out  1, m_ready  in  1, m_last  out  1 (frame output).
REQ-011 The block SHALL have ports busy  out  1 (frame in progress) and err_len  out  1 (one-cycle reject pulse).

Function
REQ-012 The FSM SHALL have states IDLE, HEADER, PAYLOAD and PAD.
REQ-013 In IDLE, start with cfg_len <= MAX_PAYLOAD_BYTES SHALL latch cfg_len/MACs, go to HEADER and set busy next cycle.
REQ-014 In IDLE, start with cfg_len > MAX_PAYLOAD_BYTES SHALL pulse err_len for one cycle and stay in IDLE.
REQ-015 start while busy SHALL be ignored without error.
REQ-016 HEADER SHALL emit dest MAC, then src MAC, then the 16-bit length, network order (most significant byte first), 14 bytes total.
REQ-017 The first header byte SHALL be valid on the cycle after start is accepted.
REQ-018 A byte SHALL transfer only when m_valid && m_ready; m_data/m_valid/m_last SHALL hold stable while m_valid && !m_ready.
REQ-019 After the last header byte, the FSM SHALL go to PAYLOAD if the latched length > 0, else to PAD.
REQ-020 In PAYLOAD: s_ready = m_ready, m_valid = s_valid, m_data = s_data; the byte counter SHALL increment per transfer.
REQ-021 After the latched length payload bytes, the FSM SHALL go to PAD if length < MIN_PAYLOAD_BYTES, else to IDLE.
REQ-022 PAD SHALL emit 8'h00 bytes until total payload+pad = MIN_PAYLOAD_BYTES, then go to IDLE.
REQ-023 m_last SHALL be asserted only with the final byte of the frame (last payload byte or last pad byte).
REQ-024 s_ready SHALL be 0 outside PAYLOAD.
REQ-025 busy SHALL deassert on the cycle after the m_last transfer; back-to-back start SHALL be accepted that cycle.
REQ-026 Byte counters SHALL be 16 bits wide and never wrap within a frame.

Reset
REQ-027 While rst_n = 0: state = IDLE; m_valid, m_last, s_ready, busy and err_len = 0; m_data = 0; counters = 0.
REQ-028 Latched MACs SHALL reset to SOURCE_MAC/DEST_MAC; latched length SHALL reset to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; no m_last SHALL be emitted for it.

Configuration
REQ-030 With ETH_HDR_VLAN_EN defined, the block SHALL add a port vlan_tci in 16, latched with start.
REQ-031 With ETH_HDR_VLAN_EN defined, a 4-byte 802.1Q tag (16'h8100, vlan_tci) SHALL be inserted between src MAC and length, giving an 18-byte header.
REQ-032 Without ETH_HDR_VLAN_EN, the vlan_tci port and tag logic SHALL be absent and the header SHALL be 14 bytes.

Structure
REQ-033 ethernet_header_pkg SHALL hold: ETH_MAC_BYTES=6, ETH_HDR_BYTES=14, ETH_VLAN_TPID=16'h8100, ETH_VLAN_BYTES=4 and the FSM state enum typedef.
REQ-034 One sub-module, eth_hdr_byte_mux, SHALL select the header byte from the latched fields by byte index (combinational).

Verification
REQ-035 cfg_len=64, m_ready=1 -> 14 header bytes starting e8 6a 64 e7 e8 29, length bytes 00 40, then 64 payload bytes; m_last on byte 78.
REQ-036 cfg_len=10 -> 14 header + 10 payload + 36 bytes 00; m_last on byte 60; s_ready low during PAD.
REQ-037 cfg_len=0 -> header, then 46 pad bytes; s_ready never asserted; m_last on byte 60.
REQ-038 cfg_len=1501 -> err_len high for 1 cycle, busy stays 0, no m_valid.
REQ-039 m_ready toggled randomly, and start pulsed while busy -> output matches the 64-byte reference stream, data stable while stalled, extra start ignored.
REQ-040 rst_n low at header byte 5, then start cfg_len=46 -> outputs cleared at once; next frame complete and correct; with ETH_HDR_VLAN_EN and vlan_tci=16'h0005, bytes 13-16 = 81 00 00 05.
